// File: rtl/buzzer_tone_driver.sv
// rtl/buzzer_tone_driver.sv - square-wave buzzer driver with volume duty and glitch-free tone changes
// Optional articulation gap between different notes: define ARTIC_GAP_EN.
module buzzer_tone_driver #(
  parameter int DIV_W   = 16,
  parameter int VOL_W   = 3,
  parameter int GAP_CYC = 120000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_enable,
  input  logic [DIV_W-1:0] i_tone_in,
  input  logic [VOL_W-1:0] i_volume,
  output logic             o_beep_out,
  output logic             o_tone_active,
  output logic             o_note_strobe,
  output logic [DIV_W-1:0] o_cur_tone
);

  if (GAP_CYC < 1) begin : g_bad_gap
    $error("GAP_CYC must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
`ifdef ARTIC_GAP_EN
    S_GAP,
`endif
    S_PLAY
  } state_t;

  localparam logic [DIV_W:0] CNT_ONE = (DIV_W+1)'(1);

  state_t           r_state, w_next_state;
  logic [DIV_W:0]   r_cnt, w_next_cnt;
  logic [DIV_W-1:0] r_cur_tone, w_next_tone;
  logic [DIV_W-1:0] r_hi_len, w_next_hi;
  logic             w_strobe;
  logic             w_wrap;
  logic             w_tone_nz;
  logic [DIV_W:0]   w_last;

`ifdef ARTIC_GAP_EN
  localparam int            GW       = $clog2(GAP_CYC + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);
  logic [GW-1:0] r_gap_cnt, w_next_gap;
`endif

  // High time scaled by volume; never zero so even the quietest note is audible.
  function automatic logic [DIV_W-1:0] calc_hi(input logic [DIV_W-1:0] tone,
                                               input logic [VOL_W-1:0] vol);
    logic [DIV_W+VOL_W-1:0] prod;
    logic [DIV_W-1:0]       hi;
    prod = {{VOL_W{1'b0}}, tone} * (DIV_W+VOL_W)'({1'b0, vol} + 1'b1);
    hi   = DIV_W'(prod >> VOL_W);
    return (hi == '0) ? DIV_W'(1) : hi;
  endfunction

  assign w_tone_nz = (i_tone_in != '0);
  assign w_last    = {r_cur_tone, 1'b0} - CNT_ONE;
  assign w_wrap    = (r_cnt == w_last);

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_next_tone  = r_cur_tone;
    w_next_hi    = r_hi_len;
    w_strobe     = 1'b0;
`ifdef ARTIC_GAP_EN
    w_next_gap   = r_gap_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (i_enable && w_tone_nz) begin
          w_next_state = S_PLAY;
          w_next_cnt   = '0;
          w_next_tone  = i_tone_in;
          w_next_hi    = calc_hi(i_tone_in, i_volume);
          w_strobe     = 1'b1;
        end
      end
      S_PLAY: begin
        if (!w_wrap) begin
          w_next_cnt = r_cnt + CNT_ONE;
        end else if (!i_enable || !w_tone_nz) begin
          w_next_state = S_IDLE;
          w_next_cnt   = '0;
          w_next_tone  = '0;
        end else if (i_tone_in == r_cur_tone) begin
          w_next_cnt = '0;
          w_next_hi  = calc_hi(r_cur_tone, i_volume);
        end else begin
`ifdef ARTIC_GAP_EN
          w_next_state = S_GAP;
          w_next_cnt   = '0;
          w_next_tone  = '0;
          w_next_gap   = '0;
`else
          w_next_cnt  = '0;
          w_next_tone = i_tone_in;
          w_next_hi   = calc_hi(i_tone_in, i_volume);
          w_strobe    = 1'b1;
`endif
        end
      end
`ifdef ARTIC_GAP_EN
      S_GAP: begin
        if (r_gap_cnt != GAP_LAST) begin
          w_next_gap = r_gap_cnt + GW'(1);
        end else if (i_enable && w_tone_nz) begin
          w_next_state = S_PLAY;
          w_next_cnt   = '0;
          w_next_tone  = i_tone_in;
          w_next_hi    = calc_hi(i_tone_in, i_volume);
          w_strobe     = 1'b1;
        end else begin
          w_next_state = S_IDLE;
        end
      end
`endif
      default: begin
        w_next_state = S_IDLE;
        w_next_cnt   = '0;
        w_next_tone  = '0;
      end
    endcase
    // Disable is a hard mute and overrides any period bookkeeping.
    if (!i_enable) begin
      w_next_state = S_IDLE;
      w_next_cnt   = '0;
      w_next_tone  = '0;
      w_strobe     = 1'b0;
`ifdef ARTIC_GAP_EN
      w_next_gap   = '0;
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_cur_tone    <= '0;
      r_hi_len      <= '0;
      o_beep_out    <= 1'b0;
      o_tone_active <= 1'b0;
      o_note_strobe <= 1'b0;
`ifdef ARTIC_GAP_EN
      r_gap_cnt     <= '0;
`endif
    end else begin
      r_state       <= w_next_state;
      r_cnt         <= w_next_cnt;
      r_cur_tone    <= w_next_tone;
      r_hi_len      <= w_next_hi;
      o_beep_out    <= (w_next_state == S_PLAY) && (w_next_cnt < {1'b0, w_next_hi});
      o_tone_active <= (w_next_state == S_PLAY);
      o_note_strobe <= w_strobe;
`ifdef ARTIC_GAP_EN
      r_gap_cnt     <= w_next_gap;
`endif
    end
  end

  assign o_cur_tone = r_cur_tone;

endmodule

// File: tb/tb_buzzer_tone_driver.sv
// tb/tb_buzzer_tone_driver.sv - directed self-checking bench for buzzer_tone_driver (GAP_CYC=8)
module tb_buzzer_tone_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] tone_in = '0;
  logic [2:0]  volume = '0;
  logic        beep_out, tone_active, note_strobe;
  logic [15:0] cur_tone;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] beeps;
  int          strobes;

  buzzer_tone_driver #(.DIV_W(16), .VOL_W(3), .GAP_CYC(8)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_enable     (enable),
    .i_tone_in    (tone_in),
    .i_volume     (volume),
    .o_beep_out   (beep_out),
    .o_tone_active(tone_active),
    .o_note_strobe(note_strobe),
    .o_cur_tone   (cur_tone)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bit i of bv holds beep_out after the (i+1)th edge of the window.
  task automatic capture(input int n, output logic [63:0] bv, output int ns);
    bv = '0;
    ns = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      bv[i] = beep_out;
      if (note_strobe) ns++;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_beep"},   64'(beep_out),    64'd0);
    chk({tag, "_active"}, 64'(tone_active), 64'd0);
    chk({tag, "_strobe"}, 64'(note_strobe), 64'd0);
    chk({tag, "_tone"},   64'(cur_tone),    64'd0);
  endtask

  initial begin
    // 1. reset, then 4 high / 4 low at full volume
    tick(); tick();
    chk_all_zero("reset");
    rst = 1'b0; enable = 1'b1; volume = 3'd7; tone_in = 16'd4;
    capture(16, beeps, strobes);
    chk("t1_wave", beeps, 64'h0F0F);
    chk("t1_strobes", 64'(strobes), 64'd1);
    chk("t1_tone", 64'(cur_tone), 64'd4);
    chk("t1_active", 64'(tone_active), 64'd1);

    // 4. enable drop while beep high
    tick();
    chk("t4_pre_beep", 64'(beep_out), 64'd1);
    enable = 1'b0;
    tick();
    chk("t4_beep", 64'(beep_out), 64'd0);
    chk("t4_active", 64'(tone_active), 64'd0);
    chk("t4_tone", 64'(cur_tone), 64'd0);

    // 2. lowest volume: 2 high / 30 low
    enable = 1'b1; volume = 3'd0; tone_in = 16'd16;
    capture(64, beeps, strobes);
    chk("t2_wave", beeps, 64'h0000_0003_0000_0003);
    chk("t2_strobes", 64'(strobes), 64'd1);
    enable = 1'b0;
    tick();

    // tone 1, volume 0: hi_len forced to 1, 2-cycle period
    enable = 1'b1; tone_in = 16'd1;
    capture(4, beeps, strobes);
    chk("tone1_wave", beeps, 64'h5);
    enable = 1'b0;
    tick();

    // 5. rest requested at cnt=1 finishes the period
    enable = 1'b1; volume = 3'd7; tone_in = 16'd4;
    tick();
    chk("t5_beep0", 64'(beep_out), 64'd1);
    tick();
    chk("t5_beep1", 64'(beep_out), 64'd1);
    tone_in = 16'd0;
    capture(10, beeps, strobes);
    chk("t5_wave", beeps, 64'h3);
    chk("t5_strobes", 64'(strobes), 64'd0);
    chk("t5_active", 64'(tone_active), 64'd0);
    chk("t5_tone", 64'(cur_tone), 64'd0);

    // 3. tone change 4 -> 6 at cnt=2
    tone_in = 16'd4;
    tick(); tick(); tick();
    tone_in = 16'd6;
`ifdef ARTIC_GAP_EN
    capture(32, beeps, strobes);
    chk("t3_wave", beeps, 64'h7E07_E001);
`else
    capture(24, beeps, strobes);
    chk("t3_wave", beeps, 64'h7E_07E1);
`endif
    chk("t3_strobes", 64'(strobes), 64'd1);
    chk("t3_tone", 64'(cur_tone), 64'd6);

    // 6. reset mid-PLAY, then a clean first period
    rst = 1'b1;
    tick();
    chk_all_zero("t6_play_rst");
    rst = 1'b0; tone_in = 16'd4;
    capture(8, beeps, strobes);
    chk("t6_replay1", beeps, 64'h0F);
    chk("t6_strobes1", 64'(strobes), 64'd1);

    // 6b. reset just after the wrap that changes tone (GAP when enabled)
    tone_in = 16'd6;
    tick();
`ifdef ARTIC_GAP_EN
    chk("t6_in_gap", 64'(tone_active), 64'd0);
`else
    chk("t6_in_gap", 64'(tone_active), 64'd1);
`endif
    tick();
    rst = 1'b1;
    tick();
    chk_all_zero("t6_gap_rst");
    rst = 1'b0; tone_in = 16'd4;
    capture(8, beeps, strobes);
    chk("t6_replay2", beeps, 64'h0F);
    chk("t6_strobes2", 64'(strobes), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
